mips_fetch_queue: RTL



---
 rtl/mips_fetch_queue.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: decoupled instruction prefetcher for the MIPS32 core.
// Sequential fetch requests go to a variable-latency instruction memory.
// Returned words land in order in a DEPTH-entry slot ring.
// The ring head is offered to decode over a valid/ready handshake.
// A redirect flushes the ring. Responses still in flight at that point are
// counted into drop_cnt and discarded as they arrive (DRAIN state).
// Optional feature: define MIPS_FETCH_ALIGN_CHK_EN to turn a misaligned
// redirect into a sticky fetch_err and a HALT state that holds until reset.
module mips_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fetch_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

`ifdef MIPS_FETCH_ALIGN_CHK_EN
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1} state_t;
`endif

  state_t state, state_next;

  logic [XLEN-1:0]  slot_pc    [DEPTH];
  logic [XLEN-1:0]  slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;
  logic [PTR_W-1:0] alloc_ptr, fill_ptr, head_ptr;
  logic [CNT_W-1:0] used;
  // inflight counts only outstanding responses that will fill a slot;
  // responses already condemned by a redirect live in drop_cnt instead.
  logic [CNT_W-1:0] inflight, drop_cnt;
  logic [XLEN-1:0]  fetch_pc;
  logic             started;

  logic             redir_take, misalign, flush, req_valid, req_fire, rsp_keep, pop;
  logic [XLEN-1:0]  redir_pc;
  logic [CNT_W-1:0] drop_new, drop_step;

  // Handshake qualifiers, redirect target, drop bookkeeping and next state
  always_comb begin
    redir_take = redirect;
    redir_pc   = {redirect_pc[XLEN-1:2], 2'b00};
    misalign   = 1'b0;
    flush      = redirect;
`ifdef MIPS_FETCH_ALIGN_CHK_EN
    redir_take = redirect && (state != ST_HALT);
    redir_pc   = redirect_pc;
    misalign   = redir_take && (redirect_pc[1:0] != 2'b00);
    flush      = redir_take || (state == ST_HALT);
`endif
    req_valid = started && (state == ST_RUN) && (used < CNT_W'(DEPTH)) && !redirect;
    req_fire  = req_valid && imem_req_ready;
    rsp_keep  = imem_rsp_valid && (drop_cnt == {CNT_W{1'b0}}) && !flush;
    pop       = slot_filled[head_ptr] && out_ready && !flush;
    drop_new  = drop_cnt + inflight - CNT_W'(imem_rsp_valid);
    if (imem_rsp_valid && (drop_cnt != {CNT_W{1'b0}})) begin
      drop_step = drop_cnt - CNT_W'(1);
    end else begin
      drop_step = drop_cnt;
    end

    state_next = state;
    case (state)
      ST_RUN: begin
        if (redir_take) begin
          state_next = (drop_new != {CNT_W{1'b0}}) ? ST_DRAIN : ST_RUN;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (redir_take) begin
          state_next = (drop_new != {CNT_W{1'b0}}) ? ST_DRAIN : ST_RUN;
        end else begin
          state_next = (drop_step == {CNT_W{1'b0}}) ? ST_RUN : ST_DRAIN;
        end
      end
`ifdef MIPS_FETCH_ALIGN_CHK_EN
      ST_HALT: state_next = ST_HALT;
`endif
      default: state_next = ST_RUN;
    endcase
    if (misalign) begin
      state_next = state_t'(2'd2);
    end else begin
      state_next = state_next;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Slot ring, pointers, counters and fetch address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i]    <= {XLEN{1'b0}};
        slot_instr[i] <= {XLEN{1'b0}};
      end
      slot_filled <= {DEPTH{1'b0}};
      alloc_ptr   <= {PTR_W{1'b0}};
      fill_ptr    <= {PTR_W{1'b0}};
      head_ptr    <= {PTR_W{1'b0}};
      used        <= {CNT_W{1'b0}};
      inflight    <= {CNT_W{1'b0}};
      drop_cnt    <= {CNT_W{1'b0}};
      fetch_pc    <= RESET_PC;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      if (flush) begin
        slot_filled <= {DEPTH{1'b0}};
        alloc_ptr   <= {PTR_W{1'b0}};
        fill_ptr    <= {PTR_W{1'b0}};
        head_ptr    <= {PTR_W{1'b0}};
        used        <= {CNT_W{1'b0}};
        inflight    <= {CNT_W{1'b0}};
        drop_cnt    <= (misalign || !redir_take) ? {CNT_W{1'b0}} : drop_new;
        if (redir_take) begin
          fetch_pc <= redir_pc;
        end
      end else begin
        drop_cnt <= drop_step;
        if (req_fire) begin
          slot_pc[alloc_ptr]     <= fetch_pc;
          slot_filled[alloc_ptr] <= 1'b0;
          alloc_ptr              <= alloc_ptr + PTR_W'(1);
          fetch_pc               <= fetch_pc + PC_STEP;
        end
        if (rsp_keep) begin
          slot_instr[fill_ptr]  <= imem_rsp_data;
          slot_filled[fill_ptr] <= 1'b1;
          fill_ptr              <= fill_ptr + PTR_W'(1);
        end
        if (pop) begin
          slot_filled[head_ptr] <= 1'b0;
          head_ptr              <= head_ptr + PTR_W'(1);
        end
        used     <= used + CNT_W'(req_fire) - CNT_W'(pop);
        inflight <= inflight + CNT_W'(req_fire) - CNT_W'(rsp_keep);
      end
    end
  end

`ifdef MIPS_FETCH_ALIGN_CHK_EN
  logic fetch_err_r;

  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err_r <= 1'b0;
    end else begin
      fetch_err_r <= fetch_err_r | misalign;
    end
  end

  assign fetch_err = fetch_err_r;
`else
  logic unused_low_pc_bits;
  assign unused_low_pc_bits = ^redirect_pc[1:0];
  assign fetch_err          = 1'b0;
`endif

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = fetch_pc;
  assign out_valid      = slot_filled[head_ptr];
  assign out_instr      = slot_instr[head_ptr];
  assign out_pc         = slot_pc[head_ptr];

endmodule
